// File: rtl/wave_pkg.sv
// Shared capture/display definitions: FSM encodings and sample RAM geometry.
package wave_pkg;

  localparam int DEPTH_LOG2 = 8;
  localparam int ADDR_W     = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } wave_state_t;

  // Signed two's-complement top byte to offset binary.
  function automatic logic [7:0] to_offset_binary(input logic [7:0] top_byte);
    return {~top_byte[7], top_byte[6:0]};
  endfunction

endpackage

// File: rtl/dffr.sv
// Flop cell with synchronous active-high reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/dffre.sv
// Flop cell with synchronous active-high reset to zero and load enable.
module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/wave_capture.sv
// Captures one buffer-half of audio starting at a positive zero crossing into
// the RAM half the display is not reading; swaps halves during display idle.
module wave_capture
  import wave_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = wave_pkg::DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W-1:0]   write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  wave_state_t           state;
  wave_state_t           state_next;
  logic [DEPTH_LOG2-1:0] count_q;
  logic [DEPTH_LOG2-1:0] count_next;
  logic                  prev_msb;
  logic                  read_index_next;
  logic                  we_next;
  logic [ADDR_W-1:0]     addr_next;
  logic                  sample_msb;

  assign state      = wave_state_t'(state_q);
  assign state_d    = state_next;
  assign sample_msb = new_sample_in[SAMPLE_W-1];

  always_comb begin
    state_next      = state;
    count_next      = count_q;
    read_index_next = read_index;
    we_next         = 1'b0;
    addr_next       = {~read_index, count_q};
    case (state)
      ARMED: begin
        if (new_sample_ready && prev_msb && !sample_msb) begin
          we_next    = 1'b1;
          addr_next  = {~read_index, {DEPTH_LOG2{1'b0}}};
          count_next = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          we_next    = 1'b1;
          count_next = count_q + 1'b1;
          // Last slot of the half: the increment wraps count back to zero.
          if (&count_q) state_next = WAIT;
        end
      end
      WAIT: begin
        if (wave_display_idle) begin
          read_index_next = ~read_index;
          state_next      = ARMED;
        end
      end
      default: state_next = ARMED;
    endcase
  end

  dffr #(.W(2)) u_state (
    .clk(clk), .reset(reset), .d(state_d), .q(state_q)
  );

  dffr #(.W(DEPTH_LOG2)) u_count (
    .clk(clk), .reset(reset), .d(count_next), .q(count_q)
  );

  dffre #(.W(1)) u_prev_msb (
    .clk(clk), .reset(reset), .en(new_sample_ready), .d(sample_msb), .q(prev_msb)
  );

  dffr #(.W(1)) u_read_index (
    .clk(clk), .reset(reset), .d(read_index_next), .q(read_index)
  );

  dffr #(.W(1)) u_write_enable (
    .clk(clk), .reset(reset), .d(we_next), .q(write_enable)
  );

  // Address and data hold their last written value between writes.
  dffre #(.W(ADDR_W)) u_write_address (
    .clk(clk), .reset(reset), .en(we_next), .d(addr_next), .q(write_address)
  );

  dffre #(.W(8)) u_write_sample (
    .clk(clk), .reset(reset), .en(we_next),
    .d(to_offset_binary(new_sample_in[SAMPLE_W-1:SAMPLE_W-8])), .q(write_sample)
  );

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: arming, fill, wait/swap, reset behaviour.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = 16'h0000;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wave_capture #(.SAMPLE_W(16), .DEPTH_LOG2(8)) dut (
    .clk(clk),
    .reset(reset),
    .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in),
    .wave_display_idle(wave_display_idle),
    .write_address(write_address),
    .write_enable(write_enable),
    .write_sample(write_sample),
    .read_index(read_index)
  );

  // Drive one cycle of inputs, then settle just after the capturing edge.
  task automatic cycle(input logic rdy, input logic [15:0] s, input logic idle, input logic rst);
    @(negedge clk);
    new_sample_ready  = rdy;
    new_sample_in     = s;
    wave_display_idle = idle;
    reset             = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Strobe and idle held high under reset must have no effect.
    cycle(1'b1, 16'hF000, 1'b1, 1'b1);
    cycle(1'b1, 16'hF000, 1'b1, 1'b1);
    tests++;
    if (write_enable !== 1'b0 || write_address !== 9'h000 || write_sample !== 8'h00 || read_index !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b addr=%h smp=%h ri=%b, want 0 000 00 0",
               write_enable, write_address, write_sample, read_index);
    end
    // prev_msb is 0 after reset, so a positive sample is not a crossing.
    cycle(1'b1, 16'h1000, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b0) begin
      fails++;
      $display("FAIL first_strobe_after_reset: we=%b, want 0", write_enable);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_arm_and_cross();
    logic [15:0] seq [4] = '{16'h0100, 16'h8000, 16'hFF00, 16'h1234};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, seq[i], 1'b0, 1'b0);
      tests++;
      if (write_enable !== 1'b0) begin
        fails++;
        $display("FAIL armed_no_write[%0d]: sample=%h we=%b, want 0", i, seq[i], write_enable);
      end
    end
    cycle(1'b1, seq[3], 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h92) begin
      fails++;
      $display("FAIL crossing_write: we=%b addr=%h smp=%h, want 1 100 92",
               write_enable, write_address, write_sample);
    end
    $display("[TB] crossing write addr=%h smp=%h", write_address, write_sample);
  endtask

  task automatic test_back_to_back_fill();
    int bad = 0;
    logic [15:0] s;
    logic [7:0]  exp_smp;
    for (int i = 1; i < 256; i++) begin
      s = {8'(i) ^ 8'h5A, 8'h33};
      exp_smp = (8'(i) ^ 8'h5A) + 8'h80;
      cycle(1'b1, s, 1'b0, 1'b0);
      if (write_enable !== 1'b1 || write_address !== (9'h100 + 9'(i)) || write_sample !== exp_smp) begin
        bad++;
        $display("FAIL fill_write[%0d]: we=%b addr=%h smp=%h, want 1 %h %h",
                 i, write_enable, write_address, write_sample, 9'h100 + 9'(i), exp_smp);
      end
    end
    tests++;
    if (bad != 0) fails++;
    $display("[TB] fill of 255 writes complete, %0d bad", bad);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b0 || write_address !== 9'h1FF) begin
      fails++;
      $display("FAIL fill_hold: we=%b addr=%h, want 0 1ff", write_enable, write_address);
    end
  endtask

  task automatic test_wait_and_swap();
    int wrote = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, (i % 2 == 0) ? 16'h8000 : 16'h1000, 1'b0, 1'b0);
      if (write_enable !== 1'b0) wrote++;
    end
    tests++;
    if (wrote != 0 || read_index !== 1'b0) begin
      fails++;
      $display("FAIL wait_ignores_strobes: writes=%0d ri=%b, want 0 0", wrote, read_index);
    end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    tests++;
    if (read_index !== 1'b1 || write_enable !== 1'b0) begin
      fails++;
      $display("FAIL wait_swap: ri=%b we=%b, want 1 0", read_index, write_enable);
    end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    tests++;
    if (read_index !== 1'b1) begin
      fails++;
      $display("FAIL ri_stable_in_armed: ri=%b, want 1", read_index);
    end
    $display("[TB] wait/swap read_index=%b", read_index);
  endtask

  task automatic test_second_crossing_and_reset();
    int bad = 0;
    // Last WAIT strobe was 0x1000, so prev_msb=0; needs a negative sample first.
    cycle(1'b1, 16'h9000, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b0) begin
      fails++;
      $display("FAIL second_armed_no_write: we=%b, want 0", write_enable);
    end
    cycle(1'b1, 16'h0500, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b1 || write_address !== 9'h000 || write_sample !== 8'h85) begin
      fails++;
      $display("FAIL second_crossing: we=%b addr=%h smp=%h, want 1 000 85",
               write_enable, write_address, write_sample);
    end
    for (int i = 1; i < 100; i++) begin
      cycle(1'b1, 16'h4000, 1'b0, 1'b0);
      if (write_enable !== 1'b1 || write_address !== 9'(i) || write_sample !== 8'hC0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL lower_half_writes: %0d bad of 99, last addr=%h", bad, write_address);
    end
    cycle(1'b1, 16'h1111, 1'b1, 1'b1);
    tests++;
    if (write_enable !== 1'b0 || write_address !== 9'h000 || write_sample !== 8'h00 || read_index !== 1'b0) begin
      fails++;
      $display("FAIL mid_active_reset: we=%b addr=%h smp=%h ri=%b, want 0 000 00 0",
               write_enable, write_address, write_sample, read_index);
    end
    cycle(1'b1, 16'h0100, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_no_write: we=%b, want 0", write_enable);
    end
    cycle(1'b1, 16'h8000, 1'b0, 1'b0);
    cycle(1'b1, 16'h2000, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'hA0) begin
      fails++;
      $display("FAIL post_reset_crossing: we=%b addr=%h smp=%h, want 1 100 a0",
               write_enable, write_address, write_sample);
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b0 || write_address !== 9'h100) begin
      fails++;
      $display("FAIL single_cycle_we: we=%b addr=%h, want 0 100", write_enable, write_address);
    end
    $display("[TB] reset mid-active and re-arm done");
  endtask

  initial begin
    test_reset();
    test_arm_and_cross();
    test_back_to_back_fill();
    test_wait_and_swap();
    test_second_crossing_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
